// File: rtl/rv_fetch_pkg.sv
// Shared types for the rv_fetch prefetch unit: the buffered entry and the FSM states.
package rv_fetch_pkg;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  typedef enum logic [1:0] {
    ST_RESET_HOLD = 2'd0,
    ST_FETCH      = 2'd1,
    ST_DISCARD    = 2'd2
  } fetch_state_e;

  localparam int ENTRY_W = $bits(fetch_entry_t);

endpackage

// File: rtl/rv_fetch_fifo.sv
// Prefetch buffer: power-of-two circular FIFO with flush; push and pop may coincide when full.
module rv_fetch_fifo
  import rv_fetch_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       i_clk,
  input  logic                       i_reset,
  input  logic                       i_flush,
  input  logic                       i_push,
  input  logic [ENTRY_W-1:0]         i_push_data,
  input  logic                       i_pop,
  output logic [ENTRY_W-1:0]         o_head,
  output logic [$clog2(DEPTH):0]     o_count,
  output logic                       o_empty
);

  localparam int AW = $clog2(DEPTH);

  logic [ENTRY_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]      rd_q, wr_q;
  logic [AW:0]        cnt_q;

  // Storage carries no reset; only pointers and count define what is live.
  always_ff @(posedge i_clk) begin
    if (i_push && !i_flush) mem_q[wr_q] <= i_push_data;
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else if (i_flush) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (i_push) wr_q <= wr_q + 1'b1;
      if (i_pop)  rd_q <= rd_q + 1'b1;
      case ({i_push, i_pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  assign o_head  = mem_q[rd_q];
  assign o_count = cnt_q;
  assign o_empty = (cnt_q == '0);

endmodule

// File: rtl/rv_fetch.sv
// Instruction prefetch with in-order bus responses, redirect discard and a small output FIFO.
// Define RV_FETCH_BYPASS_EN to forward a kept response straight to decode when the FIFO is empty.
module rv_fetch
  import rv_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_ADDR = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_pc_change,
  input  logic [31:0] i_pc_target,
  input  logic        i_stall,
  output logic        o_instr_req,
  output logic [31:0] o_instr_addr,
  input  logic        i_instr_ack,
  input  logic        i_instr_rvalid,
  input  logic [31:0] i_instr_rdata,
  output logic        o_valid,
  output logic [31:0] o_instr,
  output logic [31:0] o_pc,
  output logic [1:0]  o_dbg_state
);

  localparam int          CW      = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW:0] DEPTH_V = (CW+1)'(FIFO_DEPTH);
  localparam logic [31:0] RST_PC  = RESET_ADDR & ~32'h3;

  fetch_state_e  state_q, state_d;
  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   resp_pc_q, resp_pc_d;
  logic [CW-1:0] outst_q, outst_d;
  logic [CW-1:0] discard_q, discard_d;

  logic          accept, keep, drop, bypass, push, pop, fifo_valid, fifo_empty;
  logic [CW-1:0] fifo_count;
  fetch_entry_t  head, push_entry;
  logic [31:0]   target_aligned;

  assign target_aligned = i_pc_target & ~32'h3;
  assign accept = o_instr_req & i_instr_ack;
  assign drop   = i_instr_rvalid & (discard_q != '0);
  // A response in the redirect cycle belongs to the old stream even if nothing is pending discard.
  assign keep   = i_instr_rvalid & (discard_q == '0) & !i_pc_change;

`ifdef RV_FETCH_BYPASS_EN
  assign bypass = keep & fifo_empty & !i_stall;
`else
  assign bypass = 1'b0;
`endif

  assign push       = keep & !bypass;
  assign fifo_valid = !fifo_empty & !i_pc_change;
  assign pop        = fifo_valid & !i_stall;
  assign push_entry = '{pc: resp_pc_q, instr: i_instr_rdata};

  rv_fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .i_clk       (i_clk),
    .i_reset     (i_reset),
    .i_flush     (i_pc_change),
    .i_push      (push),
    .i_push_data (push_entry),
    .i_pop       (pop),
    .o_head      (head),
    .o_count     (fifo_count),
    .o_empty     (fifo_empty)
  );

  assign o_instr_req  = (state_q != ST_RESET_HOLD) && !i_pc_change &&
                        (({1'b0, fifo_count} + {1'b0, outst_q}) < DEPTH_V);
  assign o_instr_addr = fetch_pc_q;
  assign o_valid      = fifo_valid | bypass;
  assign o_instr      = bypass ? i_instr_rdata : (fifo_empty ? 32'h0 : head.instr);
  assign o_pc         = bypass ? resp_pc_q : (fifo_empty ? resp_pc_q : head.pc);
  assign o_dbg_state  = state_q;

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    resp_pc_d  = resp_pc_q;
    outst_d    = outst_q;
    discard_d  = discard_q;

    case ({accept, i_instr_rvalid})
      2'b10:   outst_d = outst_q + 1'b1;
      2'b01:   outst_d = outst_q - 1'b1;
      default: outst_d = outst_q;
    endcase

    if (i_pc_change) begin
      fetch_pc_d = target_aligned;
      resp_pc_d  = target_aligned;
      discard_d  = outst_q - CW'(i_instr_rvalid);
    end else begin
      if (accept) fetch_pc_d = fetch_pc_q + 32'd4;
      if (keep)   resp_pc_d  = resp_pc_q + 32'd4;
      if (drop)   discard_d  = discard_q - 1'b1;
    end

    case (state_q)
      ST_RESET_HOLD: state_d = ST_FETCH;
      ST_FETCH, ST_DISCARD: begin
        if (i_pc_change)             state_d = (discard_d != '0) ? ST_DISCARD : ST_FETCH;
        else if (discard_d == '0)    state_d = ST_FETCH;
      end
      default: state_d = ST_RESET_HOLD;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q    <= ST_RESET_HOLD;
      fetch_pc_q <= RST_PC;
      resp_pc_q  <= RST_PC;
      outst_q    <= '0;
      discard_q  <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      resp_pc_q  <= resp_pc_d;
      outst_q    <= outst_d;
      discard_q  <= discard_d;
    end
  end

endmodule
